// File: rtl/capture_ctrl_pkg.sv
// Shared types and count helpers for the logic analyzer capture sequencer.
package capture_ctrl_pkg;

    // One bit wider than the 18-bit sample counts so that 4*(0xFFFF+1) does not wrap.
    localparam int CNT_W = 19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_POST,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_SEND
    } capture_state_t;

    typedef enum logic {
        FLOW_XON,
        FLOW_XOFF
    } xon_xoff_t;

    function automatic logic [CNT_W-1:0] to_dly_smpls(input logic [15:0] cnt);
        return {1'b0, cnt, 2'b00} + CNT_W'(4);
    endfunction

    function automatic logic [CNT_W-1:0] to_rd_smpls(input logic [15:0] cnt, input int depth);
        logic [CNT_W-1:0] smpls;
        smpls = to_dly_smpls(cnt);
        if (smpls > CNT_W'(depth)) smpls = CNT_W'(depth);
        return smpls;
    endfunction

endpackage

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills the sample ring, counts post-trigger samples, then
// streams the buffer newest-first to the transmitter under XON/XOFF control.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for run (start now) or arm (wait for trigger)
// ST_ARMED   | writing samples, waiting for a qualified trigger
// ST_POST    | writing samples, counting delay samples after the trigger
// ST_RD_REQ  | read address on the RAM port (waits one cycle if a write is in flight)
// ST_RD_WAIT | RAM read data arriving, registered into tx_data_o
// ST_SEND    | tx_valid_o offered until accepted (held low while XOFF)
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int SMPL_W    = 32,
    parameter int MEM_DEPTH = 1024,
    localparam int ADDR_W   = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic              soft_reset_i,
    input  logic              run_i,
    input  logic              arm_i,
    input  logic              finish_i,
    input  logic              xon_i,
    input  logic              xoff_i,
    input  logic [15:0]       rd_cnt_i,
    input  logic [15:0]       dly_cnt_i,
    input  logic              smpl_valid_i,
    input  logic [SMPL_W-1:0] smpl_i,
    input  logic              trg_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [SMPL_W-1:0] mem_wdata_o,
    input  logic [SMPL_W-1:0] mem_rdata_i,
    output logic [SMPL_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o
);

    capture_state_t    state;
    xon_xoff_t         flow;
    xon_xoff_t         flow_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] newest;
    logic [CNT_W-1:0]  post_cnt;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  rd_smpls;
    logic [CNT_W-1:0]  dly_smpls;

    always_comb begin
        flow_next = flow;
        if (xoff_i)     flow_next = FLOW_XOFF;
        else if (xon_i) flow_next = FLOW_XON;
    end

    // A sample written on the same edge as leaving capture is itself the newest.
    assign newest = smpl_valid_i ? wr_ptr : wr_ptr - 1'b1;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state       <= ST_IDLE;
            flow        <= FLOW_XON;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            post_cnt    <= '0;
            remaining   <= '0;
            rd_smpls    <= '0;
            dly_smpls   <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            tx_data_o   <= '0;
            tx_valid_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else if (soft_reset_i) begin
            state       <= ST_IDLE;
            flow        <= FLOW_XON;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            post_cnt    <= '0;
            remaining   <= '0;
            rd_smpls    <= '0;
            dly_smpls   <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            tx_data_o   <= '0;
            tx_valid_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            flow     <= flow_next;
            case (state)
                ST_IDLE: begin
                    if (run_i || arm_i) begin
                        state     <= run_i ? ST_POST : ST_ARMED;
                        post_cnt  <= '0;
                        rd_smpls  <= to_rd_smpls(rd_cnt_i, MEM_DEPTH);
                        dly_smpls <= to_dly_smpls(dly_cnt_i);
                        busy_o    <= 1'b1;
                    end
                end
                ST_ARMED, ST_POST: begin
                    if (smpl_valid_i) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= wr_ptr;
                        mem_wdata_o <= smpl_i;
                        wr_ptr      <= wr_ptr + 1'b1;
                    end
                    if (finish_i) begin
                        state     <= ST_RD_REQ;
                        rd_ptr    <= newest;
                        remaining <= rd_smpls;
                        if (!smpl_valid_i) mem_addr_o <= newest;
                    end else if (smpl_valid_i) begin
                        if (state == ST_ARMED) begin
                            if (trg_i) begin
                                state    <= ST_POST;
                                post_cnt <= CNT_W'(1);
                            end
                        end else begin
                            post_cnt <= post_cnt + 1'b1;
                            if (post_cnt + 1'b1 == dly_smpls) begin
                                state     <= ST_RD_REQ;
                                rd_ptr    <= newest;
                                remaining <= rd_smpls;
                            end
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (mem_we_o) mem_addr_o <= rd_ptr;
                    else          state      <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    tx_data_o  <= mem_rdata_i;
                    tx_valid_o <= (flow_next == FLOW_XON);
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_valid_o && tx_ready_i) begin
                        tx_valid_o <= 1'b0;
                        rd_ptr     <= rd_ptr - 1'b1;
                        remaining  <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state      <= ST_RD_REQ;
                            mem_addr_o <= rd_ptr - 1'b1;
                        end
                    end else begin
                        tx_valid_o <= (flow_next == FLOW_XON);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized bench for capture_ctrl against a ring-buffer reference model.
module tb_capture_ctrl;
    localparam int SMPL_W    = 32;
    localparam int MEM_DEPTH = 1024;
    localparam int ADDR_W    = 10;

    logic              clk_i = 1'b0;
    logic              rst_in = 1'b0;
    logic              soft_reset_i = 1'b0, run_i = 1'b0, arm_i = 1'b0, finish_i = 1'b0;
    logic              xon_i = 1'b0, xoff_i = 1'b0;
    logic [15:0]       rd_cnt_i = '0, dly_cnt_i = '0;
    logic              smpl_valid_i = 1'b0, trg_i = 1'b0;
    logic [SMPL_W-1:0] smpl_i = '0;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [SMPL_W-1:0] mem_wdata_o;
    logic [SMPL_W-1:0] mem_rdata_i;
    logic [SMPL_W-1:0] tx_data_o;
    logic              tx_valid_o;
    logic              tx_ready_i = 1'b0;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    capture_ctrl #(.SMPL_W(SMPL_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk_i(clk_i), .rst_in(rst_in), .soft_reset_i(soft_reset_i), .run_i(run_i),
        .arm_i(arm_i), .finish_i(finish_i), .xon_i(xon_i), .xoff_i(xoff_i),
        .rd_cnt_i(rd_cnt_i), .dly_cnt_i(dly_cnt_i), .smpl_valid_i(smpl_valid_i),
        .smpl_i(smpl_i), .trg_i(trg_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .tx_data_o(tx_data_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .busy_o(busy_o)
    );

    function automatic logic [31:0] dflt_word(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Synchronous RAM, old data on a same-address read/write.
    logic [31:0] ram    [MEM_DEPTH];
    bit          ram_wr [MEM_DEPTH];
    always @(posedge clk_i) begin
        if (mem_we_o) begin
            ram[mem_addr_o]    <= mem_wdata_o;
            ram_wr[mem_addr_o] <= 1'b1;
        end
        mem_rdata_i <= ram_wr[mem_addr_o] ? ram[mem_addr_o] : dflt_word(int'(mem_addr_o));
    end

    typedef struct { int addr; logic [31:0] data; } wr_t;

    logic [31:0] ref_mem [MEM_DEPTH];
    bit          ref_wr  [MEM_DEPTH];
    wr_t         exp_wr[$];
    logic [31:0] exp_tx[$];
    logic [31:0] got[$];
    int          m_wp = 0;
    bit          m_xoff = 1'b0;
    bit          hold = 1'b0;
    logic [31:0] hold_data = '0;
    bit          flow_en = 1'b0;
    int          rdy_pct = 100;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_we"}, 64'(mem_we_o), 64'd0);
        check({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
        check({tag, "_wdata"}, 64'(mem_wdata_o), 64'd0);
        check({tag, "_txdata"}, 64'(tx_data_o), 64'd0);
        check({tag, "_txvalid"}, 64'(tx_valid_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    // One clock: called at a negedge with command inputs already set.
    task automatic step();
        bit acc;
        int r;
        wr_t w;
        if (flow_en) begin
            r      = $urandom_range(15);
            xoff_i = (r == 0) || (r == 3);
            xon_i  = (r == 1) || (r == 2) || (r == 3);
        end
        tx_ready_i = ($urandom_range(99) < rdy_pct);
        acc = tx_valid_o && tx_ready_i && !soft_reset_i;
        if (acc) got.push_back(tx_data_o);
        if (soft_reset_i) begin
            m_xoff = 1'b0;
            hold   = 1'b0;
            m_wp   = 0;
        end else begin
            if (xoff_i)     m_xoff = 1'b1;
            else if (xon_i) m_xoff = 1'b0;
            if (acc) hold = 1'b0;
            else if (tx_valid_o) begin
                hold      = 1'b1;
                hold_data = tx_data_o;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        {run_i, arm_i, finish_i, soft_reset_i, smpl_valid_i, trg_i, xon_i, xoff_i} = '0;
        if (mem_we_o) begin
            if (exp_wr.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
            else begin
                w = exp_wr.pop_front();
                check("wr_addr", 64'(mem_addr_o), 64'(w.addr));
                check("wr_data", 64'(mem_wdata_o), 64'(w.data));
            end
        end
        if (m_xoff) check("xoff_valid", 64'(tx_valid_o), 64'd0);
        if (hold) begin
            check("hold_data", 64'(tx_data_o), 64'(hold_data));
            if (!m_xoff) check("hold_valid", 64'(tx_valid_o), 64'd1);
        end
    endtask

    task automatic model_write(input logic [31:0] v);
        wr_t w;
        w.addr = m_wp;
        w.data = v;
        exp_wr.push_back(w);
        ref_mem[m_wp] = v;
        ref_wr[m_wp]  = 1'b1;
        m_wp = (m_wp + 1) % MEM_DEPTH;
    endtask

    task automatic do_soft_reset(input string tag);
        soft_reset_i = 1'b1;
        step();
        check_zero_outputs(tag);
        exp_wr.delete();
    endtask

    // Capture phase; on success leaves the expected newest-first stream in exp_tx.
    task automatic capture(input bit use_run, input bit use_arm, input int rd_cnt, input int dly_cnt,
                           input int trig_at, input int finish_at, input int valid_pct,
                           input logic [31:0] base, output bit ok);
        int n, pc, cyc, newest, rd_smpls, a;
        bit post, done, t;
        n = 0; pc = 0; cyc = 0; done = 1'b0;
        rd_cnt_i  = 16'(rd_cnt);
        dly_cnt_i = 16'(dly_cnt);
        run_i = use_run;
        arm_i = use_arm;
        post  = use_run;
        step();
        check("busy_start", 64'(busy_o), 64'd1);
        while (!done && cyc < 5000) begin
            cyc++;
            finish_i     = (finish_at >= 0) && (n >= finish_at);
            smpl_valid_i = finish_i ? (valid_pct < 100 && $urandom_range(1) == 1)
                                    : ($urandom_range(99) < valid_pct);
            t     = smpl_valid_i && (n == trig_at);
            trg_i = t || (!smpl_valid_i && $urandom_range(1) == 1);
            smpl_i = base + 32'(n);
            if (smpl_valid_i) begin
                model_write(smpl_i);
                n++;
            end
            if (finish_i) done = 1'b1;
            else if (smpl_valid_i) begin
                if (!post) begin
                    if (t) begin
                        post = 1'b1;
                        pc   = 1;
                    end
                end else begin
                    pc++;
                    if (pc == 4 * (dly_cnt + 1)) done = 1'b1;
                end
            end
            step();
        end
        ok = done;
        if (!done) begin
            check("capture_timeout", 64'd0, 64'd1);
            return;
        end
        newest   = (m_wp + MEM_DEPTH - 1) % MEM_DEPTH;
        rd_smpls = 4 * (rd_cnt + 1);
        if (rd_smpls > MEM_DEPTH) rd_smpls = MEM_DEPTH;
        exp_tx.delete();
        for (int k = 0; k < rd_smpls; k++) begin
            a = ((newest - k) % MEM_DEPTH + MEM_DEPTH) % MEM_DEPTH;
            exp_tx.push_back(ref_wr[a] ? ref_mem[a] : dflt_word(a));
        end
    endtask

    task automatic readout(input int ready_pct, input bit flow);
        int cyc, limit, n;
        got.delete();
        flow_en = flow;
        rdy_pct = ready_pct;
        cyc   = 0;
        limit = exp_tx.size() * 80 + 100;
        while (got.size() < exp_tx.size() && cyc < limit) begin
            cyc++;
            // Start/finish/sample strobes outside capture must all be ignored.
            arm_i        = ($urandom_range(7) == 0);
            run_i        = ($urandom_range(7) == 0);
            finish_i     = ($urandom_range(7) == 0);
            smpl_valid_i = $urandom_range(1) == 1;
            trg_i        = $urandom_range(1) == 1;
            step();
        end
        flow_en = 1'b0;
        check("rd_count", 64'(got.size()), 64'(exp_tx.size()));
        n = (got.size() < exp_tx.size()) ? got.size() : exp_tx.size();
        for (int k = 0; k < n; k++) check("rd_word", 64'(got[k]), 64'(exp_tx[k]));
        check("busy_end", 64'(busy_o), 64'd0);
        check("valid_end", 64'(tx_valid_o), 64'd0);
        check("wr_pending", 64'(exp_wr.size()), 64'd0);
        xon_i = 1'b1;
        step();
        rdy_pct = 100;
    endtask

    initial begin
        bit ok, ur;
        int rc, dc, vp, ta, fa, cyc;

        repeat (3) @(negedge clk_i);
        check_zero_outputs("reset");
        rst_in = 1'b1;
        @(negedge clk_i);

        // Run, immediate readout of 4 words counting from 0x10.
        capture(1'b1, 1'b0, 0, 0, -1, -1, 100, 32'h10, ok);
        if (ok) readout(100, 1'b0);

        // Arm, trigger on sample value 10, 8 words read back.
        do_soft_reset("srst_a");
        capture(1'b0, 1'b1, 1, 0, 10, -1, 100, 32'h0, ok);
        if (ok) readout(100, 1'b0);

        // Arm with no trigger past the ring size, then finish; readout wraps.
        do_soft_reset("srst_b");
        capture(1'b0, 1'b1, 3, 0, -1, 1030, 100, 32'h1000, ok);
        if (ok) readout(70, 1'b1);

        // XON/XOFF during SEND with the transmitter always ready.
        capture(1'b1, 1'b0, 7, 1, -1, -1, 80, 32'h2000, ok);
        if (ok) readout(100, 1'b1);

        // Soft reset while in POST.
        rd_cnt_i  = 16'd0;
        dly_cnt_i = 16'd50;
        run_i = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            smpl_valid_i = 1'b1;
            smpl_i = 32'h3000 + 32'(i);
            model_write(smpl_i);
            step();
        end
        do_soft_reset("srst_post");

        // Soft reset while in SEND, stalled by XOFF.
        capture(1'b1, 1'b0, 0, 0, -1, -1, 100, 32'h4000, ok);
        rdy_pct = 0;
        cyc = 0;
        while (!tx_valid_o && cyc < 20) begin
            cyc++;
            step();
        end
        check("send_reached", 64'(tx_valid_o), 64'd1);
        xoff_i = 1'b1;
        step();
        step();
        do_soft_reset("srst_send");
        rdy_pct = 100;

        // Fresh run must write from address 0 and must not be held off by XOFF.
        capture(1'b1, 1'b0, 0, 0, -1, -1, 100, 32'h5000, ok);
        if (ok) readout(100, 1'b0);

        // Maximum read count is clamped to the RAM depth.
        capture(1'b1, 1'b0, 16'hFFFF, 0, -1, -1, 100, 32'h6000, ok);
        if (ok) readout(100, 1'b0);

        // Run and arm together: run wins, so no trigger is needed.
        capture(1'b1, 1'b1, 1, 2, -1, -1, 60, 32'h7000, ok);
        if (ok) readout(100, 1'b0);

        for (int it = 0; it < 12; it++) begin
            ur = $urandom_range(1) == 1;
            rc = $urandom_range(7);
            dc = $urandom_range(7);
            vp = $urandom_range(100, 30);
            ta = ur ? -1 : $urandom_range(20);
            fa = (!ur && $urandom_range(3) == 0) ? $urandom_range(25) : -1;
            capture(ur, !ur, rc, dc, ta, fa, vp, $urandom, ok);
            if (ok) readout($urandom_range(100, 30), $urandom_range(1) == 1);
            else do_soft_reset("srst_recover");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
